// File: rtl/nes_mem_arbiter.sv
// Purpose    : serialises CPU (rd/wr) and PPU (rd) requests onto the single shared NES main-memory port.
// Latency    : read grant->ack RD_CYCLES+1 edges, write grant->ack 1 edge; back-to-back grant on the edge after ack.
// Backpressure: requests are level-held until ack; nothing is granted while load_done is low.
//
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   load_done                 memory/cartridge ready gate for new grants
//   cpu_req/we/addr/wdata     CPU request side; cpu_ack pulse, cpu_rdata held until next CPU read ack
//   ppu_req/addr              PPU read request side; ppu_ack pulse, ppu_rdata held until next PPU ack
//   mem_addr/rd_cpu/rd_ppu/wr/d  registered memory command; mem_q_cpu/mem_q_ppu result registers
//
// Build option: NES_ARB_PPU_PRIORITY_EN defined -> PPU always wins ties (fixed priority);
//               undefined -> round-robin between CPU and PPU on ties.
`timescale 1ns/1ps
module nes_mem_arbiter #(
    parameter int RD_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load_done,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [21:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        ppu_req,
    input  logic [21:0] ppu_addr,
    output logic        ppu_ack,
    output logic [7:0]  ppu_rdata,
    output logic [21:0] mem_addr,
    output logic        mem_rd_cpu,
    output logic        mem_rd_ppu,
    output logic        mem_wr,
    output logic [7:0]  mem_d,
    input  logic [7:0]  mem_q_cpu,
    input  logic [7:0]  mem_q_ppu
);

    localparam int CW = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CAP  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic        sel_ppu, sel_ppu_nxt;     // read in flight belongs to the PPU path
    logic [21:0] addr_nxt;
    logic [7:0]  d_nxt;
    logic        rd_cpu_nxt, rd_ppu_nxt, wr_nxt;
    logic        cpu_ack_nxt, ppu_ack_nxt;
    logic [7:0]  cpu_rdata_nxt, ppu_rdata_nxt;

    // A request seen while its own ack is still high is the tail of the
    // access just finished, not a new one.
    logic cpu_pend, ppu_pend, ppu_wins;
    logic grant_cpu, grant_ppu;

    assign cpu_pend = cpu_req & ~cpu_ack;
    assign ppu_pend = ppu_req & ~ppu_ack;

`ifdef NES_ARB_PPU_PRIORITY_EN
    // Video timing first: PPU takes every tie.
    assign ppu_wins = ppu_pend;
`else
    // rr_last: 1 = PPU was served last, so the CPU wins the next tie.
    logic rr_last;

    assign ppu_wins = ppu_pend & (~cpu_pend | ~rr_last);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= 1'b1;
        end else if (grant_ppu) begin
            rr_last <= 1'b1;
        end else if (grant_cpu) begin
            rr_last <= 1'b0;
        end
    end
`endif

    assign grant_ppu = (state == S_IDLE) & load_done & ppu_wins;
    assign grant_cpu = (state == S_IDLE) & load_done & ~ppu_wins & cpu_pend;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sel_ppu    <= 1'b0;
            mem_addr   <= '0;
            mem_d      <= '0;
            mem_rd_cpu <= 1'b0;
            mem_rd_ppu <= 1'b0;
            mem_wr     <= 1'b0;
            cpu_ack    <= 1'b0;
            ppu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            ppu_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel_ppu    <= sel_ppu_nxt;
            mem_addr   <= addr_nxt;
            mem_d      <= d_nxt;
            mem_rd_cpu <= rd_cpu_nxt;
            mem_rd_ppu <= rd_ppu_nxt;
            mem_wr     <= wr_nxt;
            cpu_ack    <= cpu_ack_nxt;
            ppu_ack    <= ppu_ack_nxt;
            cpu_rdata  <= cpu_rdata_nxt;
            ppu_rdata  <= ppu_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        sel_ppu_nxt   = sel_ppu;
        addr_nxt      = mem_addr;   // address held for the whole access and beyond
        d_nxt         = mem_d;
        rd_cpu_nxt    = 1'b0;
        rd_ppu_nxt    = 1'b0;
        wr_nxt        = 1'b0;
        cpu_ack_nxt   = 1'b0;
        ppu_ack_nxt   = 1'b0;
        cpu_rdata_nxt = cpu_rdata;
        ppu_rdata_nxt = ppu_rdata;

        case (state)
            S_IDLE: begin
                if (grant_ppu) begin
                    addr_nxt    = ppu_addr;
                    rd_ppu_nxt  = 1'b1;
                    sel_ppu_nxt = 1'b1;
                    cnt_nxt     = CW'(RD_CYCLES - 1);
                    state_nxt   = S_RD;
                end else if (grant_cpu) begin
                    addr_nxt = cpu_addr;
                    if (cpu_we) begin
                        d_nxt     = cpu_wdata;
                        wr_nxt    = 1'b1;
                        state_nxt = S_WR;
                    end else begin
                        rd_cpu_nxt  = 1'b1;
                        sel_ppu_nxt = 1'b0;
                        cnt_nxt     = CW'(RD_CYCLES - 1);
                        state_nxt   = S_RD;
                    end
                end
            end
            S_RD: begin
                // Strobe already spent one cycle high at the grant edge;
                // cnt counts the remaining cycles it must stay up.
                if (cnt == '0) begin
                    state_nxt = S_CAP;
                end else begin
                    cnt_nxt    = cnt - CW'(1);
                    rd_cpu_nxt = mem_rd_cpu;
                    rd_ppu_nxt = mem_rd_ppu;
                end
            end
            S_CAP: begin
                state_nxt = S_IDLE;
                if (sel_ppu) begin
                    ppu_rdata_nxt = mem_q_ppu;
                    ppu_ack_nxt   = 1'b1;
                end else begin
                    cpu_rdata_nxt = mem_q_cpu;
                    cpu_ack_nxt   = 1'b1;
                end
            end
            S_WR: begin
                state_nxt   = S_IDLE;
                cpu_ack_nxt = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nes_mem_arbiter.sv
`timescale 1ns/1ps
module tb_nes_mem_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n, load_done;

    // DUT with default RD_CYCLES=2
    logic        cpu_req, cpu_we, cpu_ack, ppu_req, ppu_ack;
    logic [21:0] cpu_addr, ppu_addr, mem_addr;
    logic [7:0]  cpu_wdata, cpu_rdata, ppu_rdata, mem_d, mem_q_cpu, mem_q_ppu;
    logic        mem_rd_cpu, mem_rd_ppu, mem_wr;

    // DUT with RD_CYCLES=3
    logic        cpu_req3, cpu_we3, cpu_ack3, ppu_req3, ppu_ack3;
    logic [21:0] cpu_addr3, ppu_addr3, mem_addr3;
    logic [7:0]  cpu_wdata3, cpu_rdata3, ppu_rdata3, mem_d3, mem_q_cpu3, mem_q_ppu3;
    logic        mem_rd_cpu3, mem_rd_ppu3, mem_wr3;

    int n_chk = 0;
    int n_pass = 0;

    nes_mem_arbiter u_dut (
        .clock(clock), .reset_n(reset_n), .load_done(load_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
        .mem_addr(mem_addr), .mem_rd_cpu(mem_rd_cpu), .mem_rd_ppu(mem_rd_ppu),
        .mem_wr(mem_wr), .mem_d(mem_d), .mem_q_cpu(mem_q_cpu), .mem_q_ppu(mem_q_ppu)
    );

    nes_mem_arbiter #(.RD_CYCLES(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .load_done(load_done),
        .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .ppu_req(ppu_req3), .ppu_addr(ppu_addr3), .ppu_ack(ppu_ack3), .ppu_rdata(ppu_rdata3),
        .mem_addr(mem_addr3), .mem_rd_cpu(mem_rd_cpu3), .mem_rd_ppu(mem_rd_ppu3),
        .mem_wr(mem_wr3), .mem_d(mem_d3), .mem_q_cpu(mem_q_cpu3), .mem_q_ppu(mem_q_ppu3)
    );

    // Behavioural memory: two 2kB regions (0x380000 CPU-side, 0x300000 PPU-side),
    // result registers load while the matching read strobe is high.
    logic [7:0]  mem0 [0:4095];
    logic [7:0]  mem3 [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_idx = '0;
    logic [7:0]  pl_dat = '0;

    function automatic logic [11:0] midx(input logic [21:0] a);
        return {a[19], a[10:0]};
    endfunction

    always @(posedge clock) begin
        if (pl_en) begin
            mem0[pl_idx] <= pl_dat;
            mem3[pl_idx] <= pl_dat;
        end
        if (mem_wr)      mem0[midx(mem_addr)] <= mem_d;
        if (mem_rd_cpu)  mem_q_cpu <= mem0[midx(mem_addr)];
        if (mem_rd_ppu)  mem_q_ppu <= mem0[midx(mem_addr)];
        if (mem_wr3)     mem3[midx(mem_addr3)] <= mem_d3;
        if (mem_rd_cpu3) mem_q_cpu3 <= mem3[midx(mem_addr3)];
        if (mem_rd_ppu3) mem_q_ppu3 <= mem3[midx(mem_addr3)];
    end

    task automatic preload(input logic [21:0] a, input logic [7:0] d);
        @(posedge clock); #1;
        pl_en = 1'b1; pl_idx = midx(a); pl_dat = d;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1 reset_n = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [50:0] outs;
        int viol;
        #1;
        outs = {cpu_ack, cpu_rdata, ppu_ack, ppu_rdata, mem_addr, mem_rd_cpu, mem_rd_ppu, mem_wr, mem_d};
        n_chk++; if (outs !== 51'd0) $display("FAIL reset_outs got=%h want 0", outs); else n_pass++;

        @(posedge clock); #1;
        reset_n = 1'b1; load_done = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h380005;
        @(posedge clock);
        @(negedge clock);
        n_chk++; if (mem_rd_cpu !== 1'b1) $display("FAIL reset_pre_grant mem_rd_cpu=%b want 1", mem_rd_cpu); else n_pass++;

        #2 reset_n = 1'b0;
        #1;
        outs = {cpu_ack, cpu_rdata, ppu_ack, ppu_rdata, mem_addr, mem_rd_cpu, mem_rd_ppu, mem_wr, mem_d};
        n_chk++; if (outs !== 51'd0) $display("FAIL reset_async got=%h want 0", outs); else n_pass++;

        load_done = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
        viol = 0;
        repeat (20) begin
            @(negedge clock);
            if (mem_rd_cpu || mem_rd_ppu || mem_wr) viol++;
        end
        n_chk++; if (viol !== 0) $display("FAIL load_gate strobe_cycles=%0d want 0", viol); else n_pass++;

        @(posedge clock); #1 load_done = 1'b1;
        @(posedge clock);
        @(negedge clock);
        n_chk++;
        if (mem_rd_cpu !== 1'b1 || mem_addr !== 22'h380005)
            $display("FAIL load_release rd=%b addr=%h want 1/380005", mem_rd_cpu, mem_addr);
        else n_pass++;
        cpu_req = 1'b0;
        repeat (6) @(posedge clock);
        #1;
    endtask

    task automatic test_cpu_write_read();
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'h380005; cpu_wdata = 8'hA5;
        @(posedge clock);
        @(negedge clock);
        n_chk++;
        if ({mem_wr, mem_rd_cpu, mem_rd_ppu, cpu_ack} !== 4'b1000 || mem_addr !== 22'h380005 || mem_d !== 8'hA5)
            $display("FAIL wr_grant wr/rc/rp/ack=%b%b%b%b addr=%h d=%h want 1000/380005/a5",
                     mem_wr, mem_rd_cpu, mem_rd_ppu, cpu_ack, mem_addr, mem_d);
        else n_pass++;
        @(posedge clock); #1 cpu_req = 1'b0;
        @(negedge clock);
        n_chk++;
        if ({mem_wr, cpu_ack} !== 2'b01) $display("FAIL wr_ack wr/ack=%b%b want 01", mem_wr, cpu_ack);
        else n_pass++;

        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0;
        @(posedge clock);
        @(negedge clock);
        n_chk++;
        if ({mem_rd_cpu, mem_rd_ppu, mem_wr, cpu_ack} !== 4'b1000 || mem_addr !== 22'h380005)
            $display("FAIL rd_grant rc/rp/wr/ack=%b%b%b%b addr=%h want 1000/380005",
                     mem_rd_cpu, mem_rd_ppu, mem_wr, cpu_ack, mem_addr);
        else n_pass++;
        @(posedge clock); @(negedge clock);
        n_chk++; if (mem_rd_cpu !== 1'b1) $display("FAIL rd_strobe2 mem_rd_cpu=%b want 1", mem_rd_cpu); else n_pass++;
        @(posedge clock); @(negedge clock);
        n_chk++;
        if ({mem_rd_cpu, cpu_ack} !== 2'b00) $display("FAIL rd_cap rd/ack=%b%b want 00", mem_rd_cpu, cpu_ack);
        else n_pass++;
        @(posedge clock); @(negedge clock);
        n_chk++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5)
            $display("FAIL rd_ack ack=%b rdata=%h want 1/a5", cpu_ack, cpu_rdata);
        else n_pass++;
        cpu_req = 1'b0;
        @(posedge clock); @(negedge clock);
        n_chk++; if (cpu_ack !== 1'b0) $display("FAIL rd_ack_pulse ack=%b want 0", cpu_ack); else n_pass++;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_back_to_back();
        int  viol, n_ack;
        logic got_ppu, exp_ppu;
        pulse_reset();
        preload(22'h380010, 8'h11);
        preload(22'h300010, 8'h22);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h380010;
        ppu_req = 1'b1; ppu_addr = 22'h300010;
        viol = 0; n_ack = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if ((32'(mem_rd_cpu) + 32'(mem_rd_ppu) + 32'(mem_wr)) > 1 || (cpu_ack && ppu_ack)) viol++;
            if (cpu_ack || ppu_ack) begin
                got_ppu = ppu_ack;
`ifdef NES_ARB_PPU_PRIORITY_EN
                exp_ppu = (n_ack % 2) == 0;
`else
                exp_ppu = (n_ack % 2) == 1;
`endif
                if (n_ack < 4) begin
                    n_chk++;
                    if (got_ppu !== exp_ppu) $display("FAIL b2b_order%0d ppu_ack=%b want %b", n_ack, got_ppu, exp_ppu);
                    else n_pass++;
                    n_chk++;
                    if (got_ppu ? (ppu_rdata !== 8'h22) : (cpu_rdata !== 8'h11))
                        $display("FAIL b2b_data%0d cpu=%h ppu=%h want 11/22", n_ack, cpu_rdata, ppu_rdata);
                    else n_pass++;
                end
                n_ack++;
            end
        end
        n_chk++; if (viol !== 0) $display("FAIL b2b_exclusive overlaps=%0d want 0", viol); else n_pass++;
        n_chk++; if (n_ack < 8) $display("FAIL b2b_count acks=%0d want >=8", n_ack); else n_pass++;
        cpu_req = 1'b0; ppu_req = 1'b0;
        repeat (8) @(posedge clock);
        #1;
    endtask

    task automatic test_tie();
        logic [1:0] exp_g;
        pulse_reset();
        cpu_we = 1'b0; cpu_addr = 22'h380010; ppu_addr = 22'h300010;
        for (int t = 0; t < 3; t++) begin
            if (t != 0) begin
                // single requester ahead of the tie: PPU before round 1, CPU before round 2
                @(posedge clock); #1;
                ppu_req = (t == 1); cpu_req = (t == 2);
                @(posedge clock); @(negedge clock);
                n_chk++;
                if ({mem_rd_cpu, mem_rd_ppu} !== ((t == 1) ? 2'b01 : 2'b10))
                    $display("FAIL single%0d rc/rp=%b%b", t, mem_rd_cpu, mem_rd_ppu);
                else n_pass++;
                cpu_req = 1'b0; ppu_req = 1'b0;
                repeat (6) @(posedge clock);
            end
            @(posedge clock); #1;
            cpu_req = 1'b1; ppu_req = 1'b1;
            @(posedge clock); @(negedge clock);
`ifdef NES_ARB_PPU_PRIORITY_EN
            exp_g = 2'b01;
`else
            exp_g = (t == 2) ? 2'b01 : 2'b10;
`endif
            n_chk++;
            if ({mem_rd_cpu, mem_rd_ppu} !== exp_g)
                $display("FAIL tie%0d rc/rp=%b%b want %b", t, mem_rd_cpu, mem_rd_ppu, exp_g);
            else n_pass++;
            cpu_req = 1'b0; ppu_req = 1'b0;
            repeat (6) @(posedge clock);
        end
        #1;
    endtask

    task automatic test_reset_mid_access();
        int  bad, n_neg;
        logic got;
        @(posedge clock); #1;
        ppu_req = 1'b1; ppu_addr = 22'h300010;
        @(posedge clock); @(negedge clock);
        n_chk++; if (mem_rd_ppu !== 1'b1) $display("FAIL rstmid_grant rp=%b want 1", mem_rd_ppu); else n_pass++;
        ppu_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if ({mem_rd_ppu, ppu_ack} !== 2'b00) $display("FAIL rstmid_drop rp/ack=%b%b want 00", mem_rd_ppu, ppu_ack);
        else n_pass++;
        @(posedge clock); #1 reset_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clock);
            if (ppu_ack || mem_rd_ppu) bad++;
        end
        n_chk++; if (bad !== 0) $display("FAIL rstmid_lost cycles=%0d want 0", bad); else n_pass++;

        @(posedge clock); #1 ppu_req = 1'b1;
        @(posedge clock);
        got = 1'b0; n_neg = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clock);
            if (ppu_ack) begin
                got = 1'b1; n_neg = i; ppu_req = 1'b0;
            end
        end
        ppu_req = 1'b0;
        // negedge 1 follows the grant edge, so an ack 3 edges after grant shows at negedge 4
        n_chk++; if (n_neg !== 4) $display("FAIL rstmid_latency negedge=%0d want 4", n_neg); else n_pass++;
        n_chk++; if (ppu_rdata !== 8'h22) $display("FAIL rstmid_data ppu_rdata=%h want 22", ppu_rdata); else n_pass++;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_rd_cycles3();
        int  strobe, n_neg, stray;
        logic got;
        preload(22'h380020, 8'h5C);
        cpu_req3 = 1'b1; cpu_we3 = 1'b0; cpu_addr3 = 22'h380020;
        @(posedge clock);
        got = 1'b0; strobe = 0; n_neg = 0; stray = 0;
        for (int i = 1; i <= 12 && !got; i++) begin
            @(negedge clock);
            if (mem_rd_cpu3) begin
                strobe++;
                if (mem_addr3 !== 22'h380020) stray++;
            end
            if (ppu_ack3 || mem_rd_ppu3 || mem_wr3) stray++;
            if (cpu_ack3) begin
                got = 1'b1; n_neg = i; cpu_req3 = 1'b0;
            end
        end
        cpu_req3 = 1'b0;
        n_chk++; if (strobe !== 3) $display("FAIL rd3_strobe cycles=%0d want 3", strobe); else n_pass++;
        n_chk++; if (n_neg !== 5) $display("FAIL rd3_latency negedge=%0d want 5", n_neg); else n_pass++;
        n_chk++; if (cpu_rdata3 !== 8'h5C) $display("FAIL rd3_data cpu_rdata=%h want 5c", cpu_rdata3); else n_pass++;
        n_chk++;
        if (stray !== 0 || ppu_rdata3 !== 8'h00) $display("FAIL rd3_quiet stray=%0d ppu_rdata=%h want 0/00", stray, ppu_rdata3);
        else n_pass++;
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; load_done = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ppu_req = 1'b0; ppu_addr = '0;
        cpu_req3 = 1'b0; cpu_we3 = 1'b0; cpu_addr3 = '0; cpu_wdata3 = '0;
        ppu_req3 = 1'b0; ppu_addr3 = '0;

        test_reset();
        test_cpu_write_read();
        test_back_to_back();
        test_tie();
        test_reset_mid_access();
        test_rd_cycles3();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
